// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with execute-stage operand forwarding.
// It captures decoded operands and control, then forwards MEM/WB results into
// the ALU operands to resolve RAW hazards.
// Optional macro IDEX_FWD_COUNT_EN: when defined, fwdcount counts forwarding
// events. When undefined, fwdcount is tied to 0.
module idex_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_e,
    input  logic               flush_e,
    input  logic [WIDTH-1:0]   rd1_d,
    input  logic [WIDTH-1:0]   rd2_d,
    input  logic [WIDTH-1:0]   signimm_d,
    input  logic [REGBITS-1:0] rs_d,
    input  logic [REGBITS-1:0] rt_d,
    input  logic [REGBITS-1:0] rd_d,
    input  logic [2:0]         alucont_d,
    input  logic               alusrc_d,
    input  logic               regdst_d,
    input  logic               regwrite_d,
    input  logic               memtoreg_d,
    input  logic               memwrite_d,
    input  logic [WIDTH-1:0]   aluout_m,
    input  logic               regwrite_m,
    input  logic [REGBITS-1:0] writereg_m,
    input  logic [WIDTH-1:0]   result_w,
    input  logic               regwrite_w,
    input  logic [REGBITS-1:0] writereg_w,
    output logic [WIDTH-1:0]   srca_e,
    output logic [WIDTH-1:0]   srcb_e,
    output logic [2:0]         alucont_e,
    output logic [WIDTH-1:0]   writedata_e,
    output logic [REGBITS-1:0] writereg_e,
    output logic [REGBITS-1:0] rs_e,
    output logic [REGBITS-1:0] rt_e,
    output logic               regwrite_e,
    output logic               memtoreg_e,
    output logic               memwrite_e,
    output logic [31:0]        fwdcount
);

    // Everything held in the E stage. An all-zero value is both the reset state
    // and a bubble.
    typedef struct packed {
        logic [WIDTH-1:0]   rd1;
        logic [WIDTH-1:0]   rd2;
        logic [WIDTH-1:0]   signimm;
        logic [REGBITS-1:0] rs;
        logic [REGBITS-1:0] rt;
        logic [REGBITS-1:0] rd;
        logic [2:0]         alucont;
        logic               alusrc;
        logic               regdst;
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
    } ex_t;

    ex_t ex_d, ex_q;

    logic fwda_m, fwda_w, fwdb_m, fwdb_w;
    logic [WIDTH-1:0] fwda, fwdb;

    // Gather the D-stage inputs into one bundle.
    always_comb begin
        ex_d          = '0;
        ex_d.rd1      = rd1_d;
        ex_d.rd2      = rd2_d;
        ex_d.signimm  = signimm_d;
        ex_d.rs       = rs_d;
        ex_d.rt       = rt_d;
        ex_d.rd       = rd_d;
        ex_d.alucont  = alucont_d;
        ex_d.alusrc   = alusrc_d;
        ex_d.regdst   = regdst_d;
        ex_d.regwrite = regwrite_d;
        ex_d.memtoreg = memtoreg_d;
        ex_d.memwrite = memwrite_d;
    end

    // E-stage register. Priority is reset, then flush, then stall, then load.
    // A flush wins over a stall so that a bubble is never held.
    always_ff @(posedge clk) begin
        if (reset)
            ex_q <= '0;
        else if (flush_e)
            ex_q <= '0;
        else if (!stall_e)
            ex_q <= ex_d;
    end

    // Forwarding source selects. Register 0 never forwards, and MEM holds the
    // newer value, so it has priority over WB.
    always_comb begin
        fwda_m = regwrite_m && (writereg_m != '0) && (writereg_m == ex_q.rs);
        fwda_w = regwrite_w && (writereg_w != '0) && (writereg_w == ex_q.rs);
        fwdb_m = regwrite_m && (writereg_m != '0) && (writereg_m == ex_q.rt);
        fwdb_w = regwrite_w && (writereg_w != '0) && (writereg_w == ex_q.rt);
        fwda   = fwda_m ? aluout_m : (fwda_w ? result_w : ex_q.rd1);
        fwdb   = fwdb_m ? aluout_m : (fwdb_w ? result_w : ex_q.rd2);
    end

    // Drive the ALU operands and the pass-through outputs.
    always_comb begin
        srca_e      = fwda;
        writedata_e = fwdb;
        srcb_e      = ex_q.alusrc ? ex_q.signimm : fwdb;
        writereg_e  = ex_q.regdst ? ex_q.rd : ex_q.rt;
        alucont_e   = ex_q.alucont;
        rs_e        = ex_q.rs;
        rt_e        = ex_q.rt;
        regwrite_e  = ex_q.regwrite;
        memtoreg_e  = ex_q.memtoreg;
        memwrite_e  = ex_q.memwrite;
    end

`ifdef IDEX_FWD_COUNT_EN
    logic [31:0] fwdcnt_q;
    logic        fwd_evt;

    assign fwd_evt = (ex_q.regwrite | ex_q.memwrite) &
                     (fwda_m | fwda_w | fwdb_m | fwdb_w);

    // Count the forwarded instructions that write something. The count holds
    // while E is stalled and wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset)
            fwdcnt_q <= '0;
        else if (!stall_e && fwd_evt)
            fwdcnt_q <= fwdcnt_q + 32'd1;
    end

    assign fwdcount = fwdcnt_q;
`else
    assign fwdcount = '0;
`endif

endmodule
